// File: rtl/egyptian_mul_pkg.sv
// Shared definitions for the sequential Egyptian (shift-and-add) multiplier.
//   egm_state_t        controller states: IDLE, RUN, DONE
//   EGM_DEFAULT_WIDTH  default operand width in bits
package egyptian_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } egm_state_t;

  localparam int EGM_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/egyptian_mul_step.sv
// One shift-and-add iteration of the Egyptian multiplier, purely combinational.
// Ports:
//   acc_i     in   2*WIDTH  running partial-product sum
//   mcand_i   in   2*WIDTH  multiplicand, already shifted for this step
//   mplier_i  in   WIDTH    remaining multiplier bits, LSB is the current one
//   acc_o     out  2*WIDTH  sum after conditionally adding mcand_i
//   mcand_o   out  2*WIDTH  multiplicand shifted left by one (top bit dropped)
//   mplier_o  out  WIDTH    multiplier shifted right by one
//   last_o    out  1        no set multiplier bits remain after this step
module egyptian_mul_step
  import egyptian_mul_pkg::*;
#(
  parameter int WIDTH = EGM_DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o,
  output logic               last_o
);

  assign acc_o    = acc_i + (mplier_i[0] ? mcand_i : '0);
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;
  // Looks at the shifted multiplier: when nothing is left to scan, this
  // step's sum is already the final product.
  assign last_o   = (mplier_o == '0);

endmodule

// File: rtl/egyptian_mul_seq.sv
// Sequential Egyptian multiplier: one adder reused for up to WIDTH cycles.
// Accepts an operand pair over a valid/ready handshake, adds one partial
// product per RUN cycle, and offers the 2*WIDTH-bit unsigned product over a
// second valid/ready handshake.
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        a/b hold an operand pair
//   in_ready   out  1        pair is accepted this cycle if in_valid
//   a          in   WIDTH    multiplier, scanned LSB first
//   b          in   WIDTH    multiplicand
//   out_valid  out  1        d holds a finished product
//   out_ready  in   1        consumer takes d this cycle
//   d          out  2*WIDTH  product a*b
//   busy       out  1        high while running or holding a result
module egyptian_mul_seq
  import egyptian_mul_pkg::*;
#(
  parameter int WIDTH      = EGM_DEFAULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] d,
  output logic               busy
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  egm_state_t           state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 out_valid_q, out_valid_d;

  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   step_mcand;
  logic [WIDTH-1:0]     step_mplier;
  logic                 step_last;
  logic                 accept;
  logic                 finish;

  egyptian_mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier),
    .last_o   (step_last)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign d         = prod_q;

  // The counter bounds the run at WIDTH steps; the early exit shortens it
  // once the remaining multiplier is empty (a=0 still takes one step).
  assign finish = (cnt_q == CNT_LAST) || (EARLY_EXIT && step_last);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = {{WIDTH{1'b0}}, b};
          mplier_d = a;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        cnt_d    = cnt_q + 1'b1;
        if (finish) begin
          prod_d      = step_acc;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Result and out_valid hold until the consumer takes them.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
